// File: rtl/frame_scheduler.sv
`timescale 1ns/1ps
// Frame scheduler: paces audio capture into a ping-pong frame buffer and hands each
// completed bank to the downstream feature-extraction stage over a valid/ack handshake.
module frame_scheduler #(
    parameter int CLK_DIV   = 6250,
    parameter int FRAME_LEN = 256,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_i,
    input  logic [11:0]       sample_in_i,
    input  logic              frame_ack_i,
    output logic              wr_en_o,
    output logic              wr_bank_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [11:0]       wr_data_o,
    output logic              frame_valid_o,
    output logic              frame_bank_o,
    output logic              overrun_o,
    output logic [7:0]        overrun_cnt_o,
    output logic              capturing_o
);

    localparam int                DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(FRAME_LEN - 1);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t            state_q,      state_d;
    logic [DIV_W-1:0]  divCnt_q,     divCnt_d;
    logic [ADDR_W-1:0] fillIdx_q,    fillIdx_d;
    logic              wrEn_q,       wrEn_d;
    logic [11:0]       wrData_q,     wrData_d;
    logic              wrBank_q,     wrBank_d;
    logic              frameValid_q, frameValid_d;
    logic              frameBank_q,  frameBank_d;
    logic              overrun_q,    overrun_d;
    logic [7:0]        overrunCnt_q, overrunCnt_d;

    logic tick;
    logic frameDone;
    logic ackTaken;

    assign tick      = (state_q == FILL) && enable_i && (divCnt_q == DIV_LAST);
    assign frameDone = wrEn_q && (fillIdx_q == IDX_LAST);
    assign ackTaken  = frameValid_q && frame_ack_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            divCnt_q     <= '0;
            fillIdx_q    <= '0;
            wrEn_q       <= 1'b0;
            wrData_q     <= '0;
            wrBank_q     <= 1'b0;
            frameValid_q <= 1'b0;
            frameBank_q  <= 1'b0;
            overrun_q    <= 1'b0;
            overrunCnt_q <= '0;
        end else begin
            state_q      <= state_d;
            divCnt_q     <= divCnt_d;
            fillIdx_q    <= fillIdx_d;
            wrEn_q       <= wrEn_d;
            wrData_q     <= wrData_d;
            wrBank_q     <= wrBank_d;
            frameValid_q <= frameValid_d;
            frameBank_q  <= frameBank_d;
            overrun_q    <= overrun_d;
            overrunCnt_q <= overrunCnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        divCnt_d     = divCnt_q;
        fillIdx_d    = fillIdx_q;
        wrEn_d       = 1'b0;
        wrData_d     = wrData_q;
        wrBank_d     = wrBank_q;
        frameValid_d = frameValid_q;
        frameBank_d  = frameBank_q;
        overrun_d    = 1'b0;
        overrunCnt_d = overrunCnt_q;

        // The sample captured on a tick is written one cycle later; the divider
        // only runs while filling, so the first tick lands CLK_DIV cycles in.
        case (state_q)
            IDLE: begin
                divCnt_d  = '0;
                fillIdx_d = '0;
                if (enable_i) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (!enable_i) begin
                    state_d   = IDLE;
                    divCnt_d  = '0;
                    fillIdx_d = '0;
                end else begin
                    divCnt_d = tick ? '0 : divCnt_q + DIV_W'(1);
                    if (tick) begin
                        wrEn_d   = 1'b1;
                        wrData_d = sample_in_i;
                    end
                    if (wrEn_q) begin
                        fillIdx_d = frameDone ? '0 : fillIdx_q + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An ack arriving with a completion frees the presented bank first,
        // so the new frame is published instead of being counted as lost.
        if (ackTaken) begin
            frameValid_d = 1'b0;
        end
        if (frameDone) begin
            if (!frameValid_q || ackTaken) begin
                frameValid_d = 1'b1;
                frameBank_d  = wrBank_q;
                wrBank_d     = ~wrBank_q;
            end else begin
                overrun_d = 1'b1;
                if (overrunCnt_q != 8'hFF) begin
                    overrunCnt_d = overrunCnt_q + 8'd1;
                end
            end
        end
    end

    assign wr_en_o       = wrEn_q;
    assign wr_bank_o     = wrBank_q;
    assign wr_addr_o     = fillIdx_q;
    assign wr_data_o     = wrData_q;
    assign frame_valid_o = frameValid_q;
    assign frame_bank_o  = frameBank_q;
    assign overrun_o     = overrun_q;
    assign overrun_cnt_o = overrunCnt_q;
    assign capturing_o   = (state_q == FILL);

endmodule

// File: tb/tb_frame_scheduler.sv
`timescale 1ns/1ps
// Bench for frame_scheduler: a timeline model predicts every output each cycle,
// and directed scenarios pin the model with hand-computed expectations.
module tb_frame_scheduler;

    localparam int CLK_DIV   = 4;
    localparam int FRAME_LEN = 8;
    localparam int ADDR_W    = 3;

    logic              clk;
    logic              rst;
    logic              enable;
    logic [11:0]       sampleIn;
    logic              frameAck;
    logic              wrEn;
    logic              wrBank;
    logic [ADDR_W-1:0] wrAddr;
    logic [11:0]       wrData;
    logic              frameValid;
    logic              frameBank;
    logic              overrun;
    logic [7:0]        overrunCnt;
    logic              capturing;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: position on the capture timeline plus the handshake status.
    bit          mFill      = 1'b0;
    int          fillCycles = 0;
    bit          mBank      = 1'b0;
    bit          mValid     = 1'b0;
    bit          mFBank     = 1'b0;
    bit          mOvr       = 1'b0;
    int          mCnt       = 0;
    logic [11:0] mData      = 12'd0;

    frame_scheduler #(
        .CLK_DIV   (CLK_DIV),
        .FRAME_LEN (FRAME_LEN),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable_i      (enable),
        .sample_in_i   (sampleIn),
        .frame_ack_i   (frameAck),
        .wr_en_o       (wrEn),
        .wr_bank_o     (wrBank),
        .wr_addr_o     (wrAddr),
        .wr_data_o     (wrData),
        .frame_valid_o (frameValid),
        .frame_bank_o  (frameBank),
        .overrun_o     (overrun),
        .overrun_cnt_o (overrunCnt),
        .capturing_o   (capturing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ramp that changes every cycle so a mistimed capture shows up as wrong data.
    initial begin
        sampleIn = 12'd0;
        forever begin
            @(posedge clk);
            #1;
            sampleIn = sampleIn + 12'd37;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // A write happens on every CLK_DIV-th cycle of continuous filling.
    function automatic bit isWriteCycle(input bit fill, input int n);
        return fill && (n > 0) && ((n % CLK_DIV) == 0);
    endfunction

    function automatic int fillAddr(input bit fill, input int n);
        if (!fill || n == 0) return 0;
        return ((n - 1) / CLK_DIV) % FRAME_LEN;
    endfunction

    task automatic compareCycle();
        bit w;
        w = isWriteCycle(mFill, fillCycles);
        checkOutput("wr_en", 32'(wrEn), 32'(w));
        checkOutput("wr_addr", 32'(wrAddr), 32'(fillAddr(mFill, fillCycles)));
        if (w) checkOutput("wr_data", 32'(wrData), 32'(mData));
        checkOutput("wr_bank", 32'(wrBank), 32'(mBank));
        checkOutput("frame_valid", 32'(frameValid), 32'(mValid));
        checkOutput("frame_bank", 32'(frameBank), 32'(mFBank));
        checkOutput("overrun", 32'(overrun), 32'(mOvr));
        checkOutput("overrun_cnt", 32'(overrunCnt), 32'(mCnt));
        checkOutput("capturing", 32'(capturing), 32'(mFill));
    endtask

    // Inputs are stable from posedge+1 to the next posedge, so the values seen
    // here are the ones the coming edge will sample.
    task automatic advanceModel();
        bit lastWrite;
        bit ackTaken;
        if (rst) begin
            mFill = 1'b0; fillCycles = 0; mBank = 1'b0; mValid = 1'b0;
            mFBank = 1'b0; mOvr = 1'b0; mCnt = 0; mData = 12'd0;
        end else begin
            lastWrite = isWriteCycle(mFill, fillCycles) && (fillAddr(mFill, fillCycles) == FRAME_LEN - 1);
            ackTaken  = mValid && frameAck;
            mOvr = 1'b0;
            if (lastWrite && mValid && !ackTaken) begin
                mOvr = 1'b1;
                if (mCnt < 255) mCnt++;
            end else if (lastWrite) begin
                mValid = 1'b1;
                mFBank = mBank;
                mBank  = ~mBank;
            end else if (ackTaken) begin
                mValid = 1'b0;
            end
            if (mFill && !enable) begin
                mFill = 1'b0; fillCycles = 0;
            end else if (mFill) begin
                fillCycles++;
            end else if (enable) begin
                mFill = 1'b1; fillCycles = 0;
            end
            if (isWriteCycle(mFill, fillCycles)) mData = sampleIn;
        end
    endtask

    always @(negedge clk) begin
        compareCycle();
        advanceModel();
    end

    task automatic applyStimulus(input bit r, input bit en, input bit ack);
        rst      = r;
        enable   = en;
        frameAck = ack;
    endtask

    task automatic cycleWait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ackOnce();
        applyStimulus(1'b0, enable, 1'b1);
        cycleWait(1);
        applyStimulus(1'b0, enable, 1'b0);
    endtask

    task automatic waitValid(input int budget, output int cycles, output int writes);
        cycles = 0;
        writes = 0;
        while (frameValid !== 1'b1 && cycles < budget) begin
            cycleWait(1);
            cycles++;
            if (wrEn === 1'b1) writes++;
        end
        checkOutput("valid_reached", 32'(frameValid), 32'd1);
    endtask

    task automatic waitWrite(input int addr, input int budget, output int cycles);
        cycles = 0;
        while (!(wrEn === 1'b1 && int'(wrAddr) == addr) && cycles < budget) begin
            cycleWait(1);
            cycles++;
        end
        checkOutput("write_reached", 32'(wrEn), 32'd1);
    endtask

    task automatic waitOverrun(input int budget);
        int c;
        c = 0;
        while (overrun !== 1'b1 && c < budget) begin
            cycleWait(1);
            c++;
        end
        checkOutput("overrun_reached", 32'(overrun), 32'd1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_wr_en"}, 32'(wrEn), 32'd0);
        checkOutput({tag, "_wr_bank"}, 32'(wrBank), 32'd0);
        checkOutput({tag, "_wr_addr"}, 32'(wrAddr), 32'd0);
        checkOutput({tag, "_wr_data"}, 32'(wrData), 32'd0);
        checkOutput({tag, "_frame_valid"}, 32'(frameValid), 32'd0);
        checkOutput({tag, "_frame_bank"}, 32'(frameBank), 32'd0);
        checkOutput({tag, "_overrun"}, 32'(overrun), 32'd0);
        checkOutput({tag, "_overrun_cnt"}, 32'(overrunCnt), 32'd0);
        checkOutput({tag, "_capturing"}, 32'(capturing), 32'd0);
    endtask

    initial begin
        int cycles;
        int writes;
        applyStimulus(1'b1, 1'b0, 1'b0);
        cycleWait(3);
        $display("[TB] reset state");
        checkAllZero("reset");
        applyStimulus(1'b0, 1'b0, 1'b0);
        cycleWait(2);

        $display("[TB] first frame");
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitValid(40, cycles, writes);
        checkOutput("first_valid_latency", 32'(cycles), 32'd34);
        checkOutput("first_frame_writes", 32'(writes), 32'd8);
        checkOutput("first_frame_bank", 32'(frameBank), 32'd0);
        checkOutput("first_wr_bank", 32'(wrBank), 32'd1);

        $display("[TB] acked frames");
        for (int i = 1; i < 4; i++) begin
            ackOnce();
            waitValid(40, cycles, writes);
            checkOutput("acked_frame_bank", 32'(frameBank), 32'(i % 2));
        end
        checkOutput("acked_overrun_cnt", 32'(overrunCnt), 32'd0);
        ackOnce();

        $display("[TB] consumer stalls");
        waitValid(40, cycles, writes);
        checkOutput("held_frame_bank", 32'(frameBank), 32'd0);
        waitOverrun(40);
        checkOutput("overrun_frame_bank", 32'(frameBank), 32'd0);
        checkOutput("overrun_wr_bank", 32'(wrBank), 32'd1);
        checkOutput("overrun_cnt_first", 32'(overrunCnt), 32'd1);
        cycleWait(256 * FRAME_LEN * CLK_DIV);
        checkOutput("overrun_cnt_sat", 32'(overrunCnt), 32'd255);
        checkOutput("held_valid", 32'(frameValid), 32'd1);

        $display("[TB] ack coincides with completion");
        waitWrite(FRAME_LEN - 1, 40, cycles);
        applyStimulus(1'b0, 1'b1, 1'b1);
        cycleWait(1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("simul_valid", 32'(frameValid), 32'd1);
        checkOutput("simul_frame_bank", 32'(frameBank), 32'd1);
        checkOutput("simul_overrun", 32'(overrun), 32'd0);
        checkOutput("simul_wr_bank", 32'(wrBank), 32'd0);
        checkOutput("simul_overrun_cnt", 32'(overrunCnt), 32'd255);

        $display("[TB] enable dropped mid-frame");
        ackOnce();
        checkOutput("released_valid", 32'(frameValid), 32'd0);
        waitWrite(3, 40, cycles);
        applyStimulus(1'b0, 1'b0, 1'b0);
        cycleWait(1);
        checkOutput("drop_capturing", 32'(capturing), 32'd0);
        checkOutput("drop_wr_addr", 32'(wrAddr), 32'd0);
        checkOutput("drop_frame_valid", 32'(frameValid), 32'd0);
        checkOutput("drop_wr_bank", 32'(wrBank), 32'd0);
        cycleWait(5);
        checkOutput("idle_wr_en", 32'(wrEn), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitWrite(0, 20, cycles);
        checkOutput("restart_latency", 32'(cycles), 32'd5);
        checkOutput("restart_wr_bank", 32'(wrBank), 32'd0);
        waitValid(40, cycles, writes);
        checkOutput("restart_frame_bank", 32'(frameBank), 32'd0);
        checkOutput("restart_next_bank", 32'(wrBank), 32'd1);

        $display("[TB] reset mid-frame");
        waitWrite(5, 40, cycles);
        checkOutput("pre_rst_valid", 32'(frameValid), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        cycleWait(1);
        checkAllZero("midrst");
        applyStimulus(1'b0, 1'b0, 1'b0);
        cycleWait(4);
        checkOutput("post_rst_capturing", 32'(capturing), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time %0t reached, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
